// File: rtl/cdc_clear_sync_pkg.sv
// Shared types for the CDC clear sequencer.
// Contents: clear_seq_phase_e (phase encoding exchanged with the peer domain),
//           CLEAR_PHASE_W (phase bus width) and a small max helper for
//           counter sizing.
package cdc_clear_sync_pkg;

    localparam int unsigned CLEAR_PHASE_W = 2;

    typedef enum logic [CLEAR_PHASE_W-1:0] {
        CLEAR_PHASE_IDLE       = 2'd0,
        CLEAR_PHASE_ISOLATE    = 2'd1,
        CLEAR_PHASE_CLEAR      = 2'd2,
        CLEAR_PHASE_POST_CLEAR = 2'd3
    } clear_seq_phase_e;

    // Largest of three values, used to size the shared phase counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/cdc_clear_seq_ctrl.sv
// One side of a CDC clear: sequences IDLE -> ISOLATE -> CLEAR -> POST_CLEAR
// -> IDLE, drives the local isolate/clear controls and offers every phase
// change to the peer over a valid/ack transfer, advancing only once the
// current phase has been accepted.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   clear_req_i           request a clear sequence (level or pulse)
//   busy_o                sequence running or pending
//   done_o                pulse when the closing IDLE offer is accepted
//   isolate_o, clear_o    local datapath controls
//   isolated_i            local datapath is quiescent
//   phase_o               current phase (clear_seq_phase_e)
//   phase_valid_o         phase_o is offered to the peer
//   phase_ack_i           peer accepts the offered phase
//   isolate_timeout_o     pulse when the isolation wait expires
module cdc_clear_seq_ctrl
    import cdc_clear_sync_pkg::*;
#(
    parameter int unsigned CLEAR_CYCLES      = 2,
    parameter int unsigned POST_CLEAR_CYCLES = 1,
    parameter int unsigned ISOLATE_TIMEOUT   = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_req_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     isolate_o,
    input  logic                     isolated_i,
    output logic                     clear_o,
    output logic [CLEAR_PHASE_W-1:0] phase_o,
    output logic                     phase_valid_o,
    input  logic                     phase_ack_i,
    output logic                     isolate_timeout_o
);

    localparam int unsigned CNT_MAX = max3(CLEAR_CYCLES, POST_CLEAR_CYCLES, ISOLATE_TIMEOUT);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    if (CLEAR_CYCLES == 0) begin : g_bad_clear_cycles
        $error("CLEAR_CYCLES must be >= 1");
    end
    if (POST_CLEAR_CYCLES == 0) begin : g_bad_post_clear_cycles
        $error("POST_CLEAR_CYCLES must be >= 1");
    end

    clear_seq_phase_e   state_q;
    clear_seq_phase_e   state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_load;
    logic               acked_q;
    logic               pending_q;

    logic               xfer;
    logic               settled;
    logic               cnt_last;
    logic               timeout_hit;
    logic               iso_ok;
    logic               start;
    logic               entry;
    logic               valid_d;
    logic               pending_d;

    // Next-phase decision and counter reload value.
    always_comb begin
        xfer        = phase_valid_o & phase_ack_i;
        // Current phase has been accepted, either earlier or right now.
        settled     = acked_q | xfer;
        cnt_last    = (cnt_q <= CNT_W'(1));
        timeout_hit = (ISOLATE_TIMEOUT != 0) && (state_q == CLEAR_PHASE_ISOLATE) &&
                      !isolated_i && (cnt_q == CNT_W'(1));
        iso_ok      = isolated_i | ((ISOLATE_TIMEOUT != 0) && cnt_last);
        // IDLE is only left once its offer is fully gone, so a request seen in
        // the done cycle becomes pending and starts one cycle later.
        start       = (state_q == CLEAR_PHASE_IDLE) & (clear_req_i | pending_q) & !phase_valid_o;

        state_d = state_q;
        unique case (state_q)
            CLEAR_PHASE_IDLE:       if (start)               state_d = CLEAR_PHASE_ISOLATE;
            CLEAR_PHASE_ISOLATE:    if (settled && iso_ok)   state_d = CLEAR_PHASE_CLEAR;
            CLEAR_PHASE_CLEAR:      if (settled && cnt_last) state_d = CLEAR_PHASE_POST_CLEAR;
            CLEAR_PHASE_POST_CLEAR: if (settled && cnt_last) state_d = CLEAR_PHASE_IDLE;
        endcase

        entry     = (state_d != state_q);
        valid_d   = entry | (phase_valid_o & !phase_ack_i);
        pending_d = (pending_q | clear_req_i) & !start;

        cnt_load = '0;
        unique case (state_d)
            CLEAR_PHASE_IDLE:       cnt_load = '0;
            CLEAR_PHASE_ISOLATE:    cnt_load = CNT_W'(ISOLATE_TIMEOUT);
            CLEAR_PHASE_CLEAR:      cnt_load = CNT_W'(CLEAR_CYCLES);
            CLEAR_PHASE_POST_CLEAR: cnt_load = CNT_W'(POST_CLEAR_CYCLES);
        endcase
    end

    // State, shared counter, flags and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= CLEAR_PHASE_IDLE;
            cnt_q             <= '0;
            acked_q           <= 1'b0;
            pending_q         <= 1'b0;
            phase_valid_o     <= 1'b0;
            busy_o            <= 1'b0;
            isolate_o         <= 1'b0;
            clear_o           <= 1'b0;
            isolate_timeout_o <= 1'b0;
        end else begin
            state_q           <= state_d;
            phase_valid_o     <= valid_d;
            pending_q         <= pending_d;
            busy_o            <= (state_d != CLEAR_PHASE_IDLE) | valid_d | pending_d;
            isolate_o         <= (state_d != CLEAR_PHASE_IDLE);
            clear_o           <= (state_d == CLEAR_PHASE_CLEAR);
            isolate_timeout_o <= timeout_hit;
            if (entry) begin
                acked_q <= 1'b0;
                cnt_q   <= cnt_load;
            end else begin
                if (xfer) acked_q <= 1'b1;
                // Saturating down-count, never wraps.
                if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign phase_o = state_q;
    assign done_o  = (state_q == CLEAR_PHASE_IDLE) & xfer;

endmodule

// File: tb/tb_cdc_clear_seq_ctrl.sv
// Bench for cdc_clear_seq_ctrl: directed sequences with hand-computed cycle
// numbers queued as expected phase transfers, clear pulses and timeout
// pulses; negedge monitors pop and compare when the DUTs present them.
module tb_cdc_clear_seq_ctrl;
    import cdc_clear_sync_pkg::*;

    typedef struct packed {
        logic [1:0]  phase;
        logic        iso;
        logic        clr;
        logic        done;
        logic        busy;
        logic [31:0] cyc;
    } xfer_t;

    typedef struct packed {
        logic [31:0] start;
        logic [31:0] len;
    } clr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, req = 1'b0, ack = 1'b1, iso = 1'b1;
    logic req2 = 1'b0, iso2 = 1'b1;

    logic       busy, done, isolate, clear, valid, tmo;
    logic [1:0] phase;
    logic       busy2, done2, isolate2, clear2, valid2, tmo2;
    logic [1:0] phase2;

    cdc_clear_seq_ctrl dut (
        .clk_i(clk), .rst_i(rst), .clear_req_i(req), .busy_o(busy), .done_o(done),
        .isolate_o(isolate), .isolated_i(iso), .clear_o(clear), .phase_o(phase),
        .phase_valid_o(valid), .phase_ack_i(ack), .isolate_timeout_o(tmo)
    );

    cdc_clear_seq_ctrl #(.ISOLATE_TIMEOUT(4)) dut_to (
        .clk_i(clk), .rst_i(rst), .clear_req_i(req2), .busy_o(busy2), .done_o(done2),
        .isolate_o(isolate2), .isolated_i(iso2), .clear_o(clear2), .phase_o(phase2),
        .phase_valid_o(valid2), .phase_ack_i(1'b1), .isolate_timeout_o(tmo2)
    );

    int unsigned cyc = 0, checks = 0, errors = 0;
    logic mon_en = 1'b0, sb_en = 1'b1;
    xfer_t q[$], q2[$];
    clr_t  qc[$];
    int unsigned qt2[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic xfer_t mk(input logic [1:0] ph, input int unsigned c);
        xfer_t e;
        e.phase = ph;
        e.iso   = (ph != 2'(CLEAR_PHASE_IDLE));
        e.clr   = (ph == 2'(CLEAR_PHASE_CLEAR));
        e.done  = (ph == 2'(CLEAR_PHASE_IDLE));
        e.busy  = 1'b1;
        e.cyc   = c;
        return e;
    endfunction

    task automatic exp_seq(input int unsigned ti, input int unsigned tc,
                           input int unsigned tp, input int unsigned tidle);
        q.push_back(mk(2'(CLEAR_PHASE_ISOLATE), ti));
        q.push_back(mk(2'(CLEAR_PHASE_CLEAR), tc));
        q.push_back(mk(2'(CLEAR_PHASE_POST_CLEAR), tp));
        q.push_back(mk(2'(CLEAR_PHASE_IDLE), tidle));
    endtask

    task automatic exp_clr(input int unsigned s, input int unsigned l);
        clr_t c;
        c.start = s;
        c.len   = l;
        qc.push_back(c);
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Main DUT monitor: scoreboard pops plus protocol invariants.
    xfer_t       e;
    clr_t        ce;
    logic [1:0]  phase_prev = 2'd0;
    logic        stall_prev = 1'b0, rst_prev = 1'b1, clr_prev = 1'b0;
    int unsigned clr_start = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid && ack && sb_en) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL xfer_unexpected: got phase %0d expected none at cycle %0d", phase, cyc);
                end else begin
                    e = q.pop_front();
                    chk("xfer_cycle", cyc, e.cyc);
                    chk("xfer_phase", phase, e.phase);
                    chk("xfer_isolate", isolate, e.iso);
                    chk("xfer_clear", clear, e.clr);
                    chk("xfer_done", done, e.done);
                    chk("xfer_busy", busy, e.busy);
                end
            end
            if (done && !(valid && ack)) chk("done_without_xfer", done, 0);
            if (tmo) chk("unexpected_timeout", tmo, 0);
            if (clear) chk("clear_implies_isolate", isolate, 1);
            if (!rst_prev && stall_prev) chk("phase_stable", phase, phase_prev);
            else if (!rst_prev && phase != phase_prev)
                chk("phase_order", phase, 2'(phase_prev + 2'd1));
            if (clear && !clr_prev) clr_start = cyc;
            if (!clear && clr_prev && sb_en) begin
                if (qc.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL clear_unexpected: got pulse at %0d expected none", clr_start);
                end else begin
                    ce = qc.pop_front();
                    chk("clear_start", clr_start, ce.start);
                    chk("clear_len", cyc - clr_start, ce.len);
                end
            end
            clr_prev   = clear;
            stall_prev = valid & !ack;
            phase_prev = phase;
            rst_prev   = rst;
        end
    end

    // Timeout-variant DUT monitor (ack tied high, so every offer transfers).
    xfer_t e2;
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid2) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL to_xfer_unexpected: got phase %0d expected none at cycle %0d", phase2, cyc);
                end else begin
                    e2 = q2.pop_front();
                    chk("to_xfer_cycle", cyc, e2.cyc);
                    chk("to_xfer_phase", phase2, e2.phase);
                    chk("to_xfer_isolate", isolate2, e2.iso);
                    chk("to_xfer_clear", clear2, e2.clr);
                    chk("to_xfer_done", done2, e2.done);
                end
            end
            if (tmo2) begin
                if (qt2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL to_pulse_unexpected: got pulse at %0d expected none", cyc);
                end else chk("to_pulse_cycle", cyc, qt2.pop_front());
            end
        end
    end

    int unsigned t;
    int unsigned n;

    initial begin
        // Reset state
        wait_cyc(3);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_phase", phase, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_isolate", isolate, 0);
        chk("rst_clear", clear, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_to_phase", phase2, 0);

        // Nominal sequence
        t = cyc + 2;
        exp_seq(t + 1, t + 2, t + 4, t + 5);
        exp_clr(t + 2, 2);
        wait_cyc(t); req = 1'b1;
        wait_cyc(t + 1); req = 1'b0;
        wait_cyc(t + 6); @(negedge clk);
        chk("nom_busy_after", busy, 0);
        chk("nom_phase_after", phase, 0);

        // Slow peer: ack low for the first 5 CLEAR cycles
        t = cyc + 3;
        exp_seq(t + 1, t + 7, t + 8, t + 9);
        exp_clr(t + 2, 6);
        wait_cyc(t); req = 1'b1;
        wait_cyc(t + 1); req = 1'b0;
        wait_cyc(t + 2); ack = 1'b0;
        wait_cyc(t + 4); @(negedge clk);
        chk("slow_phase_held", phase, 2);
        chk("slow_valid_held", valid, 1);
        wait_cyc(t + 7); ack = 1'b1;
        wait_cyc(t + 11);

        // Isolation timeout on the ISOLATE_TIMEOUT=4 instance
        t = cyc + 2;
        q2.push_back(mk(2'(CLEAR_PHASE_ISOLATE), t + 1));
        q2.push_back(mk(2'(CLEAR_PHASE_CLEAR), t + 5));
        q2.push_back(mk(2'(CLEAR_PHASE_POST_CLEAR), t + 7));
        q2.push_back(mk(2'(CLEAR_PHASE_IDLE), t + 8));
        qt2.push_back(t + 5);
        wait_cyc(t); req2 = 1'b1; iso2 = 1'b0;
        wait_cyc(t + 1); req2 = 1'b0;
        wait_cyc(t + 12); iso2 = 1'b1;

        // No timeout configured: ISOLATE waits for isolated_i
        t = cyc + 2;
        q.push_back(mk(2'(CLEAR_PHASE_ISOLATE), t + 1));
        wait_cyc(t); req = 1'b1; iso = 1'b0;
        wait_cyc(t + 1); req = 1'b0;
        wait_cyc(t + 30); @(negedge clk);
        chk("wait_phase_isolate", phase, 1);
        chk("wait_clear_low", clear, 0);
        q.push_back(mk(2'(CLEAR_PHASE_CLEAR), t + 32));
        q.push_back(mk(2'(CLEAR_PHASE_POST_CLEAR), t + 34));
        q.push_back(mk(2'(CLEAR_PHASE_IDLE), t + 35));
        exp_clr(t + 32, 2);
        wait_cyc(t + 31); iso = 1'b1;
        wait_cyc(t + 38);

        // Coalescing: three requests during a stretched CLEAR
        t = cyc + 2;
        exp_seq(t + 1, t + 6, t + 7, t + 8);
        exp_clr(t + 2, 5);
        exp_seq(t + 10, t + 11, t + 13, t + 14);
        exp_clr(t + 11, 2);
        wait_cyc(t); req = 1'b1;
        wait_cyc(t + 1); req = 1'b0;
        wait_cyc(t + 2); req = 1'b1; ack = 1'b0;
        wait_cyc(t + 3); req = 1'b0;
        wait_cyc(t + 4); req = 1'b1;
        wait_cyc(t + 5); req = 1'b0;
        wait_cyc(t + 6); req = 1'b1; ack = 1'b1;
        wait_cyc(t + 7); req = 1'b0;
        wait_cyc(t + 9); @(negedge clk);
        chk("coal_busy_between", busy, 1);
        chk("coal_phase_between", phase, 0);
        wait_cyc(t + 15); @(negedge clk);
        chk("coal_busy_end", busy, 0);
        wait_cyc(t + 25); @(negedge clk);
        chk("coal_no_third", phase, 0);

        // Request in the done cycle is kept as pending
        t = cyc + 2;
        exp_seq(t + 1, t + 2, t + 4, t + 5);
        exp_clr(t + 2, 2);
        exp_seq(t + 7, t + 8, t + 10, t + 11);
        exp_clr(t + 8, 2);
        wait_cyc(t); req = 1'b1;
        wait_cyc(t + 1); req = 1'b0;
        wait_cyc(t + 5); req = 1'b1;
        wait_cyc(t + 6); req = 1'b0;
        @(negedge clk);
        chk("donereq_busy", busy, 1);
        wait_cyc(t + 14);

        // Reset in CLEAR, then a clean sequence
        t = cyc + 2;
        q.push_back(mk(2'(CLEAR_PHASE_ISOLATE), t + 1));
        q.push_back(mk(2'(CLEAR_PHASE_CLEAR), t + 2));
        exp_clr(t + 2, 1);
        wait_cyc(t); req = 1'b1;
        wait_cyc(t + 1); req = 1'b0;
        wait_cyc(t + 2); rst = 1'b1;
        wait_cyc(t + 3); rst = 1'b0;
        @(negedge clk);
        chk("mrst_phase", phase, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_isolate", isolate, 0);
        chk("mrst_clear", clear, 0);
        chk("mrst_done", done, 0);
        t = cyc + 3;
        exp_seq(t + 1, t + 2, t + 4, t + 5);
        exp_clr(t + 2, 2);
        wait_cyc(t); req = 1'b1;
        wait_cyc(t + 1); req = 1'b0;
        wait_cyc(t + 8);

        // Random ack / isolated_i stalls: invariants only
        sb_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ack = 1'($urandom_range(0, 1));
            iso = 1'($urandom_range(0, 1));
            req = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
        end
        req = 1'b0; ack = 1'b1; iso = 1'b1;
        n = 0;
        while (n < 60 && (busy || valid || phase != 2'd0)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_idle", {busy, valid, phase}, 0);
        @(negedge clk);
        sb_en = 1'b1;

        wait_cyc(cyc + 5);
        chk("q_empty", q.size(), 0);
        chk("qc_empty", qc.size(), 0);
        chk("q2_empty", q2.size(), 0);
        chk("qt2_empty", qt2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
